// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry
// and the address of the optional hardwired zero register.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
    localparam int ZERO_ADDR    = 0;

endpackage : regfile_pkg

// File: rtl/reg_file_entry.sv
// One register-file slot: a data register plus its busy (outstanding producer)
// bit. Set has priority over clear; the caller folds flush into clear.
module reg_file_entry #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wen,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_set,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);

    logic [DATA_W-1:0] r_data;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else begin
            if (i_wen) begin
                r_data <= i_wdata;
            end
            if (i_set) begin
                r_busy <= 1'b1;
            end else if (i_clr) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;

endmodule : reg_file_entry

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with same-cycle write bypass, optional
// hardwired zero register and a per-register busy scoreboard for RAW stalls.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy2,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              flush
);

    logic [DATA_W-1:0] w_data  [NUM_REGS];
    logic              w_busy  [NUM_REGS];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin : g_zero
                assign w_data[gi] = '0;
                assign w_busy[gi] = 1'b0;
            end else begin : g_entry
                logic w_wr_hit;
                logic w_set_hit;

                // Flush beats set; set beats the writeback clear (younger producer).
                assign w_wr_hit  = wen && (waddr == ADDR_W'(gi));
                assign w_set_hit = set_busy && (set_addr == ADDR_W'(gi)) && !flush;

                reg_file_entry #(
                    .DATA_W (DATA_W)
                ) u_entry (
                    .clk     (clk),
                    .rst     (rst),
                    .i_wen   (w_wr_hit),
                    .i_wdata (wdata),
                    .i_set   (w_set_hit),
                    .i_clr   (flush || w_wr_hit),
                    .o_data  (w_data[gi]),
                    .o_busy  (w_busy[gi])
                );
            end
        end
    endgenerate

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic w_match;
            logic w_is_zero;

            assign w_match   = wen && (waddr == w_raddr[gi]);
            assign w_is_zero = (ZERO_REG != 0) && (w_raddr[gi] == ADDR_W'(ZERO_ADDR));

            // Outputs are forced quiet while reset is held so a pending bypass cannot leak through.
            assign w_rdata[gi] = !rst                    ? '0 :
                                 (w_match && !w_is_zero) ? wdata :
                                                           w_data[w_raddr[gi]];
            assign w_rbusy[gi] = rst && w_busy[w_raddr[gi]] && !w_match;
        end
    endgenerate

    assign rdata1 = w_rdata[0];
    assign rbusy1 = w_rbusy[0];
    assign rdata2 = w_rdata[1];
    assign rbusy2 = w_rbusy[1];

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed checks of reg_file_sb: reset, bypass, zero register, scoreboard
// priority, flush and asynchronous reset.
module tb_reg_file_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              rbusy1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy2;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              set_busy;
    logic [ADDR_W-1:0] set_addr;
    logic              flush;

    int n_checks;
    int n_fail;

    reg_file_sb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (16),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .rbusy1   (rbusy1),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .rbusy2   (rbusy2),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .flush    (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end else begin
            $display("check %s: got %h ok", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen      = 1'b0;
        set_busy = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic mark_busy(input logic [ADDR_W-1:0] a);
        set_busy = 1'b1;
        set_addr = a;
        tick();
        set_busy = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        raddr1   = 4'd3;
        raddr2   = 4'd15;
        waddr    = '0;
        wdata    = '0;
        set_addr = '0;
        idle_inputs();

        // Reset, then release
        repeat (3) tick();
        check("rst_held_rdata1", 32'(rdata1), 32'h0);
        rst = 1'b1;
        #1;
        check("rst_rdata1", 32'(rdata1), 32'h0);
        check("rst_rdata2", 32'(rdata2), 32'h0);
        check("rst_rbusy1", 32'(rbusy1), 32'h0);
        check("rst_rbusy2", 32'(rbusy2), 32'h0);

        // Write with same-cycle bypass, then read from storage on both ports
        tick();
        wen = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; raddr1 = 4'd5; raddr2 = 4'd6;
        #1;
        check("bypass_rdata1", 32'(rdata1), 32'hBEEF);
        check("bypass_other_port", 32'(rdata2), 32'h0);
        tick();
        wen = 1'b0; wdata = 16'h0000; raddr2 = 4'd5;
        #1;
        check("stored_rdata1", 32'(rdata1), 32'hBEEF);
        check("stored_rdata2_same", 32'(rdata2), 32'hBEEF);

        // Zero register: write and set_busy both ignored
        wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF;
        set_busy = 1'b1; set_addr = 4'd0; raddr2 = 4'd0;
        #1;
        check("zero_cyc_rdata2", 32'(rdata2), 32'h0);
        check("zero_cyc_rbusy2", 32'(rbusy2), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("zero_after_rdata2", 32'(rdata2), 32'h0);
        check("zero_after_rbusy2", 32'(rbusy2), 32'h0);

        // Scoreboard set, then writeback clears with bypass
        raddr1 = 4'd7; raddr2 = 4'd7;
        set_busy = 1'b1; set_addr = 4'd7;
        #1;
        check("sb_before_edge", 32'(rbusy1), 32'h0);
        tick();
        set_busy = 1'b0;
        #1;
        check("sb_rbusy1", 32'(rbusy1), 32'h1);
        check("sb_rbusy2", 32'(rbusy2), 32'h1);
        tick();
        check("sb_hold", 32'(rbusy1), 32'h1);
        wen = 1'b1; waddr = 4'd7; wdata = 16'h0042;
        #1;
        check("wb_rbusy1", 32'(rbusy1), 32'h0);
        check("wb_rdata1", 32'(rdata1), 32'h0042);
        tick();
        wen = 1'b0;
        #1;
        check("wb_after_rbusy1", 32'(rbusy1), 32'h0);
        check("wb_after_rdata1", 32'(rdata1), 32'h0042);

        // Simultaneous set and write-clear: set wins
        mark_busy(4'd9);
        raddr1 = 4'd9;
        #1;
        check("sc_busy_pre", 32'(rbusy1), 32'h1);
        wen = 1'b1; waddr = 4'd9; wdata = 16'h1234;
        set_busy = 1'b1; set_addr = 4'd9;
        tick();
        idle_inputs();
        #1;
        check("sc_rdata", 32'(rdata1), 32'h1234);
        check("sc_rbusy", 32'(rbusy1), 32'h1);

        // Flush overrides a same-edge set; data write in that edge still lands
        mark_busy(4'd2);
        mark_busy(4'd4);
        mark_busy(4'd6);
        raddr1 = 4'd2; raddr2 = 4'd4;
        #1;
        check("fl_pre_busy2", 32'(rbusy1), 32'h1);
        check("fl_pre_busy4", 32'(rbusy2), 32'h1);
        flush = 1'b1; set_busy = 1'b1; set_addr = 4'd8;
        wen = 1'b1; waddr = 4'd3; wdata = 16'h3333;
        tick();
        idle_inputs();
        #1;
        check("fl_busy2", 32'(rbusy1), 32'h0);
        check("fl_busy4", 32'(rbusy2), 32'h0);
        raddr1 = 4'd6; raddr2 = 4'd8;
        #1;
        check("fl_busy6", 32'(rbusy1), 32'h0);
        check("fl_busy8", 32'(rbusy2), 32'h0);
        raddr1 = 4'd9; raddr2 = 4'd3;
        #1;
        check("fl_busy9", 32'(rbusy1), 32'h0);
        check("fl_data3", 32'(rdata2), 32'h3333);

        // Asynchronous reset mid-cycle clears storage without a clock edge
        tick();
        wen = 1'b1; waddr = 4'd4; wdata = 16'hA5A5;
        tick();
        wen = 1'b0;
        raddr1 = 4'd4; raddr2 = 4'd5;
        #1;
        check("ar_pre_data4", 32'(rdata1), 32'hA5A5);
        #1;
        rst = 1'b0;
        #1;
        check("ar_data4", 32'(rdata1), 32'h0);
        check("ar_data5", 32'(rdata2), 32'h0);

        // Write lost when reset overlaps its edge; storage stays cleared after release
        wen = 1'b1; waddr = 4'd10; wdata = 16'h5A5A;
        tick();
        wen = 1'b0;
        rst = 1'b1;
        raddr1 = 4'd10;
        #1;
        check("ar_lost_write10", 32'(rdata1), 32'h0);
        check("ar_after_data5", 32'(rdata2), 32'h0);
        raddr1 = 4'd4; raddr2 = 4'd9;
        #1;
        check("ar_after_data4", 32'(rdata1), 32'h0);
        check("ar_after_busy9", 32'(rbusy2), 32'h0);
        check("ar_after_data9", 32'(rdata2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file, successor to the single-bit read-enable cell: DATA_W x NUM_REGS storage with two combinational read ports and one write port.
- Adds write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard that the decode stage uses to detect RAW hazards and stall.
- Sits between decode (read, busy-set) and writeback (write, busy-clear) in the pipeline.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived).
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- rbusy1  out  1  register at raddr1 has an outstanding producer.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data.
- rbusy2  out  1  register at raddr2 has an outstanding producer.
- wen  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- set_busy  in  1  mark register set_addr busy (instruction issued with this destination).
- set_addr  in  ADDR_W  destination being marked busy.
- flush  in  1  clear all busy bits (pipeline squash).

Behaviour:
- Reset (rst low, asynchronous): all registers = 0 and all busy bits = 0. Read outputs are therefore 0 and not busy while reset is held. Reset takes effect immediately, even mid-write; the write in that cycle is lost.
- Write: on a rising edge with wen=1, reg[waddr] <= wdata. Also busy[waddr] <= 0, unless the set rule below applies.
- Zero register (ZERO_REG=1, addr 0):
  - Writes are dropped.
  - set_busy to addr 0 is ignored.
  - Reads return 0 with busy=0.
  - The bypass never forwards to addr 0.
- Reads: combinational, zero-latency.
  - If wen=1 and waddr == raddrN (and not the zero register), rdataN = wdata (same-cycle bypass). Otherwise rdataN = reg[raddrN].
  - rbusyN = busy[raddrN] AND NOT (wen AND waddr == raddrN). The bypassed value is final, so it is not reported busy.
  - Both read ports are fully independent and may address the same register.
- Busy update priority per register, evaluated each rising edge:
  1. flush=1: all busy bits <= 0. This overrides set_busy and clears in the same edge. The register data write still occurs.
  2. set_busy=1 with set_addr == r: busy[r] <= 1. Set wins over a same-cycle write-clear to the same register, because a new producer is younger than the one writing back.
  3. wen=1 with waddr == r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Writing a register that is not busy is legal and simply updates the data.
- set_busy on a register that is already busy is legal; the bit stays 1, with no counting.
- X on addresses while the corresponding enable is 0 must not affect state.

Decomposition:
- Shared package (regfile_pkg): DATA_W and NUM_REGS defaults, derived ADDR_W, and a ZERO_ADDR constant.
- One natural sub-module, reg_file_entry: a DATA_W-bit register plus busy bit with write-enable, set and clear inputs and asynchronous active-low reset. It is generated NUM_REGS times (entry 0 is replaced by constant zero when ZERO_REG=1).
- Read mux, bypass compare and busy-priority logic live in the top level.

Test Plan:
- Reset then read: hold rst low, release; raddr1=3, raddr2=15 -> rdata1=0, rdata2=0, rbusy1=rbusy2=0.
- Write/read and bypass: wen=1, waddr=5, wdata=16'hBEEF with raddr1=5 in the same cycle -> rdata1=16'hBEEF combinationally. Next cycle, wen=0 -> rdata1 still 16'hBEEF from storage.
- Zero register: wen=1, waddr=0, wdata=16'hFFFF, plus set_busy=1, set_addr=0 -> raddr2=0 gives rdata2=0 and rbusy2=0, both in the same cycle and after the edge.
- Scoreboard: set_busy addr 7 -> next cycle rbusy1=1 at raddr1=7. Later wen=1, waddr=7, wdata=16'h0042 -> that cycle rbusy1=0 and rdata1=16'h0042 (bypass); busy[7]=0 after the edge.
- Simultaneous set/clear: busy[9]=1; in one cycle wen=1, waddr=9, wdata=16'h1234 and set_busy=1, set_addr=9 -> after the edge rdata=16'h1234 and rbusy=1.
- Flush and async reset: mark regs 2, 4 and 6 busy, then pulse flush together with set_busy addr 8 -> all four busy bits 0. Then write reg 4 = 16'hA5A5 and drop rst low mid-cycle -> rdata at addr 4 = 0 immediately, with no clock edge.
